// File: rtl/quad_encoder_decoder.sv
// Purpose : quadrature (A/B) encoder decoder with 2-flop sync, per-channel
//           debounce, 4x decode, signed wrapping position count, sticky
//           illegal-transition flag.
// Latency : pad edge -> count = 2 (sync) + DEBOUNCE + 1 clk cycles.
// Backpressure: none; the decoder follows the pads every cycle.
//
// Ports:
//   clk      system clock, rising edge
//   resetb   asynchronous active-low reset
//   enc_a    raw encoder A (async)
//   enc_b    raw encoder B (async)
//   enable   count enable; state tracking continues while low
//   clear    synchronous clear of count and err (wins over step/index)
//   enc_idx  raw index pulse, used only when QENC_INDEX_EN is defined
//   count    WIDTH-bit two's-complement position, wraps
//   step     one-cycle pulse per applied count change
//   dir      direction of last applied step (1 = +1, 0 = -1)
//   err      sticky illegal-transition flag
//
// Build option: define QENC_INDEX_EN to add a synchronised, debounced index
// input whose filtered rising edge zeroes the count.

module quad_encoder_decoder #(
   parameter int WIDTH    = 16,
   parameter int DEBOUNCE = 4,
   parameter int DB_W     = 4
) (
   input  logic             clk,
   input  logic             resetb,
   input  logic             enc_a,
   input  logic             enc_b,
   input  logic             enable,
   input  logic             clear,
   input  logic             enc_idx,
   output logic [WIDTH-1:0] count,
   output logic             step,
   output logic             dir,
   output logic             err
);

`ifdef QENC_INDEX_EN
   localparam int NCH = 3;   // channel 0 = A, 1 = B, 2 = index
`else
   localparam int NCH = 2;   // channel 0 = A, 1 = B
`endif

   // Counter value on which a still-differing input is accepted.
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

   logic [NCH-1:0]  raw;
   logic [NCH-1:0]  sync_m;
   logic [NCH-1:0]  sync_s;
   logic [NCH-1:0]  filt;
   logic [DB_W-1:0] db_cnt [NCH];

   logic [1:0] ab_cur;
   logic [1:0] ab_prev;
   logic       fwd;
   logic       rev;
   logic       illegal;
   logic       idx_rise;

`ifdef QENC_INDEX_EN
   assign raw = {enc_idx, enc_b, enc_a};
`else
   assign raw = {enc_b, enc_a};
   // Index pad has no function in this build.
   logic unused_idx;
   assign unused_idx = enc_idx;
`endif

   // ------------------------------------------------------------------
   // Two-flop synchronisers for every channel.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         sync_m <= '0;
         sync_s <= '0;
      end else begin
         sync_m <= raw;
         sync_s <= sync_m;
      end
   end

   // ------------------------------------------------------------------
   // Debounce: the filtered value follows the synchronised value only
   // after it has differed for DEBOUNCE consecutive cycles. Any cycle of
   // agreement restarts the count, so shorter glitches are swallowed.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         filt <= '0;
         for (int i = 0; i < NCH; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (sync_s[i] == filt[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               filt[i]   <= sync_s[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DB_W'(1);
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // 4x decode of {A,B} against the previous filtered state.
   // ------------------------------------------------------------------
   assign ab_cur = {filt[0], filt[1]};

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         ab_prev <= 2'b00;
      end else begin
         ab_prev <= ab_cur;
      end
   end

   always_comb begin
      fwd     = 1'b0;
      rev     = 1'b0;
      illegal = 1'b0;
      case ({ab_prev, ab_cur})
         4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: fwd     = 1'b1;
         4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: rev     = 1'b1;
         4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: illegal = 1'b1;
         default: ;
      endcase
   end

   // ------------------------------------------------------------------
   // Index: rising edge of the filtered index zeroes the count.
   // ------------------------------------------------------------------
`ifdef QENC_INDEX_EN
   logic idx_d;

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         idx_d <= 1'b0;
      end else begin
         idx_d <= filt[2];
      end
   end

   assign idx_rise = filt[2] & ~idx_d;
`else
   assign idx_rise = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Count / step / dir / err. Priority: clear, then index, then step.
   // err still latches an illegal transition on an index cycle; only
   // clear suppresses it.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         count <= '0;
         step  <= 1'b0;
         dir   <= 1'b0;
         err   <= 1'b0;
      end else begin
         step <= 1'b0;
         if (clear) begin
            count <= '0;
            err   <= 1'b0;
         end else begin
            if (illegal) begin
               err <= 1'b1;
            end
            if (idx_rise) begin
               count <= '0;
            end else if (enable && (fwd || rev)) begin
               count <= fwd ? count + WIDTH'(1) : count - WIDTH'(1);
               step  <= 1'b1;
               dir   <= fwd;
            end
         end
      end
   end

endmodule
